// File: rtl/hex_display_arbiter_if.sv
// Requester-side bus of hex_display_arbiter: per-requester req/data lanes in,
// one-hot ack, current owner and busy back out.
interface hex_display_arbiter_if #(
   parameter int N_REQ = 4
);
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]    req;
   logic [24*N_REQ-1:0] data;
   logic [N_REQ-1:0]    ack;
   logic [OW-1:0]       owner;
   logic                busy;

   modport master (
      output req,
      output data,
      input  ack,
      input  owner,
      input  busy
   );

   modport slave (
      input  req,
      input  data,
      output ack,
      output owner,
      output busy
   );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the six-digit HEX display between N_REQ requesters.
// Optional build macro HEX_LEADING_ZERO_BLANK_EN blanks leading zero digits (HEX5..HEX1).
module hex_display_arbiter #(
   parameter int N_REQ = 4,
   parameter int DWELL = 50_000_000
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET,
   hex_display_arbiter_if.slave  bus,
   output logic [6:0]            HEX0,
   output logic [6:0]            HEX1,
   output logic [6:0]            HEX2,
   output logic [6:0]            HEX3,
   output logic [6:0]            HEX4,
   output logic [6:0]            HEX5
);

   localparam int          CW = $clog2(DWELL + 1);
   localparam int          OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned NR = N_REQ;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [23:0]      disp_q,  disp_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q,   ptr_d;
   logic [N_REQ-1:0] ack_q,   ack_d;

   logic [23:0]      lane [N_REQ];
   logic             found;
   logic [OW-1:0]    win;

   for (genvar g = 0; g < N_REQ; g++) begin : g_lane
      assign lane[g] = bus.data[24*g +: 24];
   end

   // Search begins one past the last winner so it drops to lowest priority.
   always_comb begin : rr_search
      int unsigned idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned i = 1; i <= NR; i++) begin
         idx = {{(32-OW){1'b0}}, ptr_q} + i;
         if (idx >= NR) begin
            idx = idx - NR;
         end
         if (!found && bus.req[idx[OW-1:0]]) begin
            found = 1'b1;
            win   = idx[OW-1:0];
         end
      end
   end

   always_comb begin : fsm_next
      state_d = state_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               disp_d     = lane[win];
               owner_d    = win;
               ptr_d      = win;
               ack_d[win] = 1'b1;
               cnt_d      = CW'(DWELL - 1);
               state_d    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         disp_q  <= '0;
         owner_q <= '0;
         ptr_q   <= OW'(N_REQ - 1);
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.owner = owner_q;
   assign bus.busy  = (state_q == ST_HOLD);

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   logic [6:0] seg   [6];
   logic [5:0] blank;

   always_comb begin : decode
      for (int unsigned k = 0; k < 6; k++) begin
         seg[k] = seg7(disp_q[4*k +: 4]);
      end
   end

`ifdef HEX_LEADING_ZERO_BLANK_EN
   logic [5:0] zero;

   always_comb begin : zero_flags
      for (int unsigned k = 0; k < 6; k++) begin
         zero[k] = (disp_q[4*k +: 4] == 4'h0);
      end
   end

   // A digit blanks only while every digit above it is also blank; HEX0 always shows.
   always_comb begin : blank_chain
      blank    = '0;
      blank[5] = zero[5];
      blank[4] = blank[5] & zero[4];
      blank[3] = blank[4] & zero[3];
      blank[2] = blank[3] & zero[2];
      blank[1] = blank[2] & zero[1];
   end
`else
   assign blank = '0;
`endif

   assign HEX0 = blank[0] ? 7'h7F : seg[0];
   assign HEX1 = blank[1] ? 7'h7F : seg[1];
   assign HEX2 = blank[2] ? 7'h7F : seg[2];
   assign HEX3 = blank[3] ? 7'h7F : seg[3];
   assign HEX4 = blank[4] ? 7'h7F : seg[4];
   assign HEX5 = blank[5] ? 7'h7F : seg[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed self-checking bench for hex_display_arbiter (DWELL=4 and DWELL=2 instances).
module tb_hex_display_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hex_display_arbiter_if #(.N_REQ(4)) bus4 ();
   hex_display_arbiter_if #(.N_REQ(4)) bus2 ();

   logic [6:0] a0, a1, a2, a3, a4, a5;
   logic [6:0] b0, b1, b2, b3, b4, b5;
   logic [41:0] hex4, hex2;
   assign hex4 = {a5, a4, a3, a2, a1, a0};
   assign hex2 = {b5, b4, b3, b2, b1, b0};

   hex_display_arbiter #(.N_REQ(4), .DWELL(4)) u_dut4 (
      .CLOCK_50(clk), .RESET(rst), .bus(bus4),
      .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5)
   );

   hex_display_arbiter #(.N_REQ(4), .DWELL(2)) u_dut2 (
      .CLOCK_50(clk), .RESET(rst), .bus(bus2),
      .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5)
   );

`ifdef HEX_LEADING_ZERO_BLANK_EN
   localparam logic [41:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [41:0] HEX_70  = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40};
`else
   localparam logic [41:0] HEX_RST = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [41:0] HEX_70  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40};
`endif
   localparam logic [41:0] HEX_12AB3F = {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E};
   localparam logic [41:0] HEX_345678 = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [41:0] HEX_ABCDEF = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle4();
      for (int i = 0; i < 20 && bus4.busy === 1'b1; i++) tick();
      n_checks++;
      if (bus4.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle4_timeout: busy=%b required 0", bus4.busy);
      end
   endtask

   task automatic test_reset();
      bus4.req = '0; bus4.data = '0;
      bus2.req = '0; bus2.data = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (hex4 !== HEX_RST) begin n_fail++; $display("FAIL reset_hex4: got %h required %h", hex4, HEX_RST); end
      n_checks++;
      if (hex2 !== HEX_RST) begin n_fail++; $display("FAIL reset_hex2: got %h required %h", hex2, HEX_RST); end
      n_checks++;
      if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus4.busy); end
      n_checks++;
      if (bus4.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b required 0000", bus4.ack); end
      n_checks++;
      if (bus4.owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d required 0", bus4.owner); end
   endtask

   task automatic test_single();
      logic exp_busy;
      bus4.data[23:0] = 24'h12AB3F;
      bus4.req = 4'b0001;
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b required 0001", bus4.ack); end
      n_checks++;
      if (bus4.owner !== 2'd0) begin n_fail++; $display("FAIL single_owner: got %0d required 0", bus4.owner); end
      n_checks++;
      if (bus4.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_g: got %b required 1", bus4.busy); end
      n_checks++;
      if (hex4 !== HEX_12AB3F) begin n_fail++; $display("FAIL single_hex: got %h required %h", hex4, HEX_12AB3F); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_busy = (k < 4);
         n_checks++;
         if (bus4.ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_hold k=%0d: got %b required 0000", k, bus4.ack); end
         n_checks++;
         if (bus4.busy !== exp_busy) begin n_fail++; $display("FAIL single_busy k=%0d: got %b required %b", k, bus4.busy, exp_busy); end
      end
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0001) begin n_fail++; $display("FAIL single_regrant: got %b required 0001", bus4.ack); end
      bus4.req = '0;
      wait_idle4();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack;
      bus2.data = {24'h333333, 24'h222222, 24'h111111, 24'h000000};
      bus2.req  = 4'b1111;
      for (int k = 0; k <= 12; k++) begin
         tick();
         exp_ack = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
         n_checks++;
         if (bus2.ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack k=%0d: got %b required %b", k, bus2.ack, exp_ack); end
         if (k % 3 == 0) begin
            n_checks++;
            if (bus2.owner !== 2'((k / 3) % 4)) begin
               n_fail++; $display("FAIL rr_owner k=%0d: got %0d required %0d", k, bus2.owner, (k / 3) % 4);
            end
         end
      end
      bus2.req = '0;
      for (int i = 0; i < 20 && bus2.busy === 1'b1; i++) tick();
      n_checks++;
      if (bus2.busy !== 1'b0) begin n_fail++; $display("FAIL idle2_timeout: busy=%b required 0", bus2.busy); end
   endtask

   task automatic test_withdraw();
      bus4.data[23:0] = 24'h345678;
      bus4.req = 4'b0001;
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0001) begin n_fail++; $display("FAIL wd_first_ack: got %b required 0001", bus4.ack); end
      bus4.req = 4'b0000;
      tick();
      bus4.req = 4'b0010;
      n_checks++;
      if (bus4.ack !== 4'b0000) begin n_fail++; $display("FAIL wd_ack c1: got %b required 0000", bus4.ack); end
      tick();
      bus4.req = 4'b0000;
      for (int k = 2; k <= 8; k++) begin
         n_checks++;
         if (bus4.ack !== 4'b0000) begin n_fail++; $display("FAIL wd_ack c%0d: got %b required 0000", k, bus4.ack); end
         tick();
      end
      n_checks++;
      if (hex4 !== HEX_345678) begin n_fail++; $display("FAIL wd_hex: got %h required %h", hex4, HEX_345678); end
      n_checks++;
      if (bus4.owner !== 2'd0) begin n_fail++; $display("FAIL wd_owner: got %0d required 0", bus4.owner); end
      n_checks++;
      if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL wd_busy: got %b required 0", bus4.busy); end
   endtask

   task automatic test_reset_mid_hold();
      bus4.data[71:48] = 24'hABCDEF;
      bus4.req = 4'b0100;
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0100) begin n_fail++; $display("FAIL rmh_ack0: got %b required 0100", bus4.ack); end
      n_checks++;
      if (bus4.owner !== 2'd2) begin n_fail++; $display("FAIL rmh_owner0: got %0d required 2", bus4.owner); end
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus4.busy !== 1'b0) begin n_fail++; $display("FAIL rmh_async_busy: got %b required 0", bus4.busy); end
      n_checks++;
      if (bus4.owner !== 2'd0) begin n_fail++; $display("FAIL rmh_async_owner: got %0d required 0", bus4.owner); end
      n_checks++;
      if (hex4 !== HEX_RST) begin n_fail++; $display("FAIL rmh_async_hex: got %h required %h", hex4, HEX_RST); end
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0100) begin n_fail++; $display("FAIL rmh_regrant_ack: got %b required 0100", bus4.ack); end
      n_checks++;
      if (bus4.owner !== 2'd2) begin n_fail++; $display("FAIL rmh_regrant_owner: got %0d required 2", bus4.owner); end
      n_checks++;
      if (hex4 !== HEX_ABCDEF) begin n_fail++; $display("FAIL rmh_regrant_hex: got %h required %h", hex4, HEX_ABCDEF); end
      bus4.req = '0;
      wait_idle4();
   endtask

   task automatic test_blank();
      bus4.data[23:0] = 24'h000070;
      bus4.req = 4'b0001;
      tick();
      n_checks++;
      if (bus4.ack !== 4'b0001) begin n_fail++; $display("FAIL blank_ack: got %b required 0001", bus4.ack); end
      n_checks++;
      if (hex4 !== HEX_70) begin n_fail++; $display("FAIL blank_hex: got %h required %h", hex4, HEX_70); end
      bus4.req = '0;
      wait_idle4();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_withdraw();
      test_reset_mid_hold();
      test_blank();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the board's six-digit seven-segment display (HEX5..HEX0) between up to N_REQ requesters. Each requester offers a 24-bit hex value with a req/ack handshake. A round-robin arbiter grants one request at a time, latches its value and holds it on the display for a minimum dwell time before the next grant. The block sits between the application logic and the HEX pins of the DE0-CV top level, replacing direct combinational drive of the display.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DWELL, 50_000_000: minimum display hold in CLOCK_50 cycles (1 s); must be ≥ 1; counter width $clog2(DWELL+1).

- CLOCK_50  input  1  system clock, all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- req  input  N_REQ  request per requester; level, held until ack.
- data  input  24*N_REQ  requester i value at [24*i+23:24*i]; nibble 5 maps to HEX5, nibble 0 to HEX0.
- ack  output  N_REQ  one-cycle pulse, one-hot; the granted value was captured.
- owner  output  $clog2(N_REQ)  index of the requester whose value is displayed.
- busy  output  1  high while the dwell is running.
- HEX0..HEX5  output  7 each  active-low segments, bit0=a .. bit6=g.

## Operation
- FSM states:
  - IDLE: if |req, grant, else stay.
  - HOLD: decrement the dwell counter; at count 0 go to IDLE.
- Round-robin: the search starts at ptr+1 mod N_REQ and takes the first asserted req. On a grant, ptr ← granted index, so the last winner gets lowest priority next time.
- On the grant edge (IDLE, |req sampled):
  - disp ← data slice of the winner.
  - owner ← winner.
  - ack[winner] ← 1; ack clears at the next edge.
  - counter ← DWELL-1; state ← HOLD.
- busy = (state == HOLD).
- Requests are never captured in HOLD. A req that drops before its grant is withdrawn: no ack and no capture. Only the sampled req vector is used.
- HEXn is combinationally decoded from disp nibble n:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Reset values: state IDLE, disp 0, owner 0, ack 0, busy 0, ptr N_REQ-1 (so requester 0 has first priority). HEX outputs are per Configuration (all 7'h40 without the macro).
- RESET mid-HOLD aborts immediately to the reset values. Any pending req is granted again after release, with requester 0 at highest priority.

## Timing
- Grant edge G: ack, owner, disp and busy update at G; HEX is valid in the same cycle as ack (latency 1 from sampled req).
- busy stays high for exactly DWELL cycles after G. IDLE is reached at G+DWELL.
- Earliest next grant is at G+DWELL+1, so the minimum ack-to-ack spacing is DWELL+1 cycles.
- The same requester re-asserting (or holding) req is re-granted only if no other req is asserted in that IDLE cycle.
- The ptr wrap from N_REQ-1 to 0 is modular; no requester is skipped.

## Configuration
- HEX_LEADING_ZERO_BLANK_EN defined:
  - Scanning from HEX5 down, each digit is blanked (7'h7F) while it and all higher digits are zero.
  - HEX0 is never blanked.
  - Reset display: HEX5..HEX1 = 7F, HEX0 = 40.
- Undefined: all six digits are always decoded, and reset shows 000000 (all 7'h40).
- Arbitration and timing are identical in both builds.

## Test plan
- Reset release with no req (DWELL=4): HEX all 40 (or 7F×5 + 40 with the macro), busy=0, ack=0, owner=0.
- req=0001, data0=0x12AB3F, DWELL=4:
  - ack=0001 for one cycle; HEX5..0 = 79,24,08,03,30,0E; owner=0.
  - busy high for 4 cycles; the next grant is no earlier than 5 cycles after the ack.
- req=1111 held constantly, DWELL=2: acks come in the order 0,1,2,3,0, spaced 3 cycles apart.
- Assert req=0010 during HOLD, then drop it before HOLD ends: no ack[1]; the display keeps the previous value.
- RESET pulse mid-HOLD with req=0100 held: outputs return to reset values asynchronously; after release, ack=0100 on the first edge.
- With macro, data=0x000070: HEX5..HEX2=7F, HEX1=78, HEX0=40. Without macro, HEX5..HEX2=40.
